// File: rtl/frontend_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : frontend_ctrl_if
// Description : Bundle of the frontend sequencer's control, redirect and host
//               byte-stream signals.
//               master : the environment (pipeline + host loader)
//               slave  : frontend_ctrl
//               Inputs to the sequencer : core_stall, redir_valid/target,
//                 load_start, load_end, byte_valid/data
//               Outputs of the sequencer: byte_ready, pcsel, target, stall_o,
//                 flush_o, dbg_sig/addr/instr, busy, loaded_words, overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface frontend_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              core_stall;
  logic              redir_valid;
  logic [31:0]       redir_target;
  logic              load_start;
  logic              load_end;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [1:0]        pcsel;
  logic [31:0]       target;
  logic              stall_o;
  logic              flush_o;
  logic              dbg_sig;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_instr;
  logic              busy;
  logic [ADDR_W:0]   loaded_words;
  logic              overflow;

  modport master (
    output core_stall, redir_valid, redir_target, load_start, load_end,
           byte_valid, byte_data,
    input  byte_ready, pcsel, target, stall_o, flush_o, dbg_sig, dbg_addr,
           dbg_instr, busy, loaded_words, overflow
  );

  modport slave (
    input  core_stall, redir_valid, redir_target, load_start, load_end,
           byte_valid, byte_data,
    output byte_ready, pcsel, target, stall_o, flush_o, dbg_sig, dbg_addr,
           dbg_instr, busy, loaded_words, overflow
  );
endinterface
`default_nettype wire

// File: rtl/frontend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frontend_ctrl
// Description : Fetch frontend sequencer. In RUN it turns execute-stage
//               redirects into PCSEL/target, keeping a redirect pending
//               across stalls. On load_start it halts fetch, assembles host
//               bytes little-endian into 32-bit words written over the debug
//               imem port, then flushes the fetch pipe and restarts at PC 0.
// Ports       : clk  - clock
//               nrst - asynchronous active-low reset
//               bus  - frontend_ctrl_if.slave (see interface for members)
// Revision    : 1.0 - initial release
// ============================================================================
module frontend_ctrl #(
  parameter int IMEM_DEPTH   = 1024,
  parameter int ADDR_W       = 10,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          nrst,
  frontend_ctrl_if.slave bus
);

  localparam int              FW      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [FW-1:0]   FLAST_C = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t          state_q;
  logic [FW-1:0]   fcnt_q;
  logic [ADDR_W:0] word_cnt_q;
  logic [1:0]      byte_cnt_q;
  logic [31:0]     asm_q;
  logic [31:0]     asm_d;
  logic            end_q;       // load_end seen; FLUSH follows the pending WRITE
  logic            pend_q;
  logic [31:0]     pend_tgt_q;
  logic [ADDR_W:0] loaded_q;
  logic            ovf_q;

  logic w_full;
  logic w_accept;
  logic w_last;
  logic w_has_bytes;

  assign w_full      = (word_cnt_q == DEPTH_C);
  assign w_accept    = (state_q == S_LOAD) && bus.byte_valid && !w_full;
  assign w_last      = w_accept && (byte_cnt_q == 2'd3);
  // Partial word (including a byte arriving this cycle) must be padded out.
  assign w_has_bytes = (byte_cnt_q != 2'd0) || w_accept;

  // Little-endian byte insertion; asm_q is cleared per word so unfilled
  // upper bytes read as zero when a partial word is written.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_FLUSH;
      fcnt_q     <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      end_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      loaded_q   <= '0;
      ovf_q      <= 1'b0;
    end else if (bus.load_start) begin
      state_q    <= S_LOAD;
      fcnt_q     <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      end_q      <= 1'b0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus.redir_valid && bus.core_stall) begin
            pend_q     <= 1'b1;
            pend_tgt_q <= bus.redir_target;
          end else if (!bus.core_stall) begin
            pend_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.byte_valid && w_full) ovf_q <= 1'b1;
          if (w_accept) begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
          if (w_last || (bus.load_end && w_has_bytes)) begin
            state_q <= S_WRITE;
            end_q   <= bus.load_end;
          end else if (bus.load_end) begin
            state_q  <= S_FLUSH;
            fcnt_q   <= '0;
            loaded_q <= word_cnt_q;
          end
        end
        S_WRITE: begin
          word_cnt_q <= word_cnt_q + 1'b1;
          byte_cnt_q <= '0;
          asm_q      <= '0;
          if (end_q || bus.load_end) begin
            state_q  <= S_FLUSH;
            fcnt_q   <= '0;
            loaded_q <= word_cnt_q + 1'b1;
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_FLUSH: begin
          if (fcnt_q == FLAST_C) state_q <= S_RUN;
          else                   fcnt_q  <= fcnt_q + 1'b1;
        end
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  always_comb begin
    bus.byte_ready = 1'b0;
    bus.pcsel      = 2'b00;
    bus.target     = '0;
    bus.stall_o    = 1'b0;
    bus.flush_o    = 1'b0;
    bus.dbg_sig    = 1'b0;
    bus.dbg_addr   = '0;
    bus.dbg_instr  = '0;
    bus.busy       = 1'b1;
    case (state_q)
      S_RUN: begin
        bus.busy    = 1'b0;
        bus.stall_o = bus.core_stall;
        // A fresh redirect takes precedence over (and replaces) a pending one.
        if (bus.redir_valid) begin
          bus.pcsel  = 2'b10;
          bus.target = bus.redir_target;
        end else if (pend_q) begin
          bus.pcsel  = 2'b10;
          bus.target = pend_tgt_q;
        end
        bus.flush_o = (bus.pcsel == 2'b10) && !bus.core_stall;
      end
      S_LOAD: begin
        bus.stall_o    = 1'b1;
        bus.byte_ready = !w_full;
      end
      S_WRITE: begin
        bus.stall_o   = 1'b1;
        bus.dbg_sig   = 1'b1;
        bus.dbg_addr  = 32'(word_cnt_q);
        bus.dbg_instr = asm_q;
      end
      default: begin
        bus.pcsel   = 2'b01;
        bus.flush_o = 1'b1;
      end
    endcase
  end

  assign bus.loaded_words = loaded_q;
  assign bus.overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_frontend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frontend_ctrl
// Description : Self-checking bench for frontend_ctrl. A large-memory
//               instance is compared every cycle against a behavioural model
//               (phase + byte queue); a 4-word instance exercises overflow.
//               Directed literal checks pin the model's key results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frontend_ctrl;
  localparam int DEPTH = 1024, AW = 10, FC = 2;
  localparam int SDEPTH = 4, SAW = 2;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  frontend_ctrl_if #(.ADDR_W(AW))  bb();
  frontend_ctrl_if #(.ADDR_W(SAW)) sb();

  frontend_ctrl #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .FLUSH_CYCLES(FC)) u_big (
    .clk(clk), .nrst(nrst), .bus(bb.slave));
  frontend_ctrl #(.IMEM_DEPTH(SDEPTH), .ADDR_W(SAW), .FLUSH_CYCLES(FC)) u_small (
    .clk(clk), .nrst(nrst), .bus(sb.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the large instance ----------------
  // phase: 0 = running, 1 = loading (incl. write cycles), 2 = flushing
  int          m_phase = 2;
  int          m_left  = FC;
  bit          m_pend  = 0;
  logic [31:0] m_ptgt  = '0;
  logic [7:0]  m_cur[$];
  int          m_words = 0;
  bit          m_wnow  = 0;
  bit          m_end   = 0;
  logic [31:0] m_wword = '0;
  int          m_loaded = 0;
  bit          m_ovf   = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_phase = 2; m_left = FC; m_pend = 0; m_ptgt = '0; m_cur.delete();
      m_words = 0; m_wnow = 0; m_end = 0; m_loaded = 0; m_ovf = 0;
    end else if (bb.load_start) begin
      m_phase = 1; m_cur.delete(); m_words = 0; m_wnow = 0; m_end = 0;
      m_pend = 0; m_ovf = 0;
    end else if (m_phase == 0) begin
      if (bb.redir_valid && bb.core_stall) begin
        m_pend = 1; m_ptgt = bb.redir_target;
      end else if (!bb.core_stall) m_pend = 0;
    end else if (m_phase == 2) begin
      m_left--;
      if (m_left == 0) m_phase = 0;
    end else if (m_wnow) begin
      m_words++; m_cur.delete(); m_wnow = 0;
      if (m_end || bb.load_end) begin
        m_phase = 2; m_left = FC; m_loaded = m_words;
      end
    end else begin
      if (bb.byte_valid) begin
        if (m_words < DEPTH) m_cur.push_back(bb.byte_data);
        else m_ovf = 1;
      end
      if (m_cur.size() == 4 || (bb.load_end && m_cur.size() > 0)) begin
        m_wnow = 1; m_end = bb.load_end; m_wword = '0;
        foreach (m_cur[i]) m_wword |= 32'(m_cur[i]) << (8 * i);
      end else if (bb.load_end) begin
        m_phase = 2; m_left = FC; m_loaded = m_words;
      end
    end
  end

  logic [1:0]  e_pcsel;
  logic [31:0] e_tgt, e_addr, e_instr;
  logic        e_stall, e_flush, e_busy, e_dbg, e_ready;

  always @(negedge clk) begin
    e_pcsel = 2'b00; e_tgt = '0; e_addr = '0; e_instr = '0;
    e_stall = 0; e_flush = 0; e_busy = 1; e_dbg = 0; e_ready = 0;
    if (m_phase == 0) begin
      e_busy  = 0;
      e_stall = bb.core_stall;
      if (bb.redir_valid)  begin e_pcsel = 2'b10; e_tgt = bb.redir_target; end
      else if (m_pend)     begin e_pcsel = 2'b10; e_tgt = m_ptgt; end
      e_flush = (e_pcsel == 2'b10) && !bb.core_stall;
    end else if (m_phase == 1) begin
      e_stall = 1;
      if (m_wnow) begin
        e_dbg = 1; e_addr = 32'(m_words); e_instr = m_wword;
      end else e_ready = (m_words < DEPTH);
    end else begin
      e_pcsel = 2'b01; e_flush = 1;
    end
    chk("pcsel",        bb.pcsel,        e_pcsel);
    chk("target",       bb.target,       e_tgt);
    chk("stall_o",      bb.stall_o,      e_stall);
    chk("flush_o",      bb.flush_o,      e_flush);
    chk("busy",         bb.busy,         e_busy);
    chk("dbg_sig",      bb.dbg_sig,      e_dbg);
    chk("dbg_addr",     bb.dbg_addr,     e_addr);
    chk("dbg_instr",    bb.dbg_instr,    e_instr);
    chk("byte_ready",   bb.byte_ready,   e_ready);
    chk("loaded_words", bb.loaded_words, 64'(m_loaded));
    chk("overflow",     bb.overflow,     m_ovf);
  end

  // ---------------- write collectors (for literal checks) ----------------
  logic [31:0] wr_addr[16];
  logic [31:0] wr_data[16];
  int          wr_n = 0;
  logic [31:0] s_first = '0;
  logic [31:0] s_last_addr = '0;
  int          s_wr_n = 0;

  always @(negedge clk) begin
    if (bb.dbg_sig && wr_n < 16) begin
      wr_addr[wr_n] = bb.dbg_addr; wr_data[wr_n] = bb.dbg_instr; wr_n++;
    end
    if (sb.dbg_sig) begin
      if (s_wr_n == 0) s_first = sb.dbg_instr;
      s_last_addr = sb.dbg_addr;
      s_wr_n++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic big_start();
    bb.load_start = 1'b1; cyc(); bb.load_start = 1'b0;
  endtask

  task automatic big_end();
    bb.load_end = 1'b1; cyc(); bb.load_end = 1'b0;
  endtask

  task automatic big_byte(input logic [7:0] b);
    bit acc = 0;
    bb.byte_valid = 1'b1; bb.byte_data = b;
    for (int k = 0; k < 8 && !acc; k++) begin
      if (bb.byte_ready) acc = 1;
      cyc();
    end
    bb.byte_valid = 1'b0;
    chk("byte_accept", acc, 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (bb.busy && k < 50) begin cyc(); k++; end
    chk(nm, bb.busy, 1'b0);
  endtask

  logic [7:0] prog1[8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] prog2[6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

  initial begin
    bb.core_stall = 0; bb.redir_valid = 0; bb.redir_target = '0;
    bb.load_start = 0; bb.load_end = 0; bb.byte_valid = 0; bb.byte_data = '0;
    sb.core_stall = 0; sb.redir_valid = 0; sb.redir_target = '0;
    sb.load_start = 0; sb.load_end = 0; sb.byte_valid = 0; sb.byte_data = '0;

    // reset release: two flush cycles then run
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    chk("rel_pcsel0", bb.pcsel, 2'b01);
    chk("rel_flush0", bb.flush_o, 1'b1);
    cyc();
    chk("rel_pcsel1", bb.pcsel, 2'b01);
    cyc();
    chk("run_pcsel", bb.pcsel, 2'b00);
    chk("run_busy", bb.busy, 1'b0);

    // two full words
    wr_n = 0;
    big_start();
    foreach (prog1[i]) big_byte(prog1[i]);
    big_end();
    wait_idle("load1_idle");
    chk("l1_nwr",   wr_n, 2);
    chk("l1_addr0", wr_addr[0], 32'd0);
    chk("l1_data0", wr_data[0], 32'h0050_0013);
    chk("l1_addr1", wr_addr[1], 32'd1);
    chk("l1_data1", wr_data[1], 32'h0010_0093);
    chk("l1_loaded", bb.loaded_words, 2);

    // partial last word is zero-padded
    wr_n = 0;
    big_start();
    foreach (prog2[i]) big_byte(prog2[i]);
    big_end();
    wait_idle("load2_idle");
    chk("l2_nwr",   wr_n, 2);
    chk("l2_data0", wr_data[0], 32'hDDCC_BBAA);
    chk("l2_data1", wr_data[1], 32'h0000_2211);
    chk("l2_loaded", bb.loaded_words, 2);

    // redirect held across a 3-cycle stall
    cyc();
    bb.core_stall = 1; bb.redir_valid = 1; bb.redir_target = 32'h40; #1;
    chk("rd_pcsel0", bb.pcsel, 2'b10);
    chk("rd_tgt0", bb.target, 32'h40);
    chk("rd_flush0", bb.flush_o, 1'b0);
    cyc(); bb.redir_valid = 0; #1;
    chk("rd_pcsel1", bb.pcsel, 2'b10);
    chk("rd_tgt1", bb.target, 32'h40);
    cyc();
    chk("rd_tgt2", bb.target, 32'h40);
    cyc(); bb.core_stall = 0; #1;
    chk("rd_pcsel3", bb.pcsel, 2'b10);
    chk("rd_flush3", bb.flush_o, 1'b1);
    cyc();
    chk("rd_pcsel4", bb.pcsel, 2'b00);

    // newer redirect overwrites the pending one
    bb.core_stall = 1; bb.redir_valid = 1; bb.redir_target = 32'h80; cyc();
    bb.redir_target = 32'h123; cyc();
    bb.redir_valid = 0; cyc();
    bb.core_stall = 0; #1;
    chk("ow_tgt", bb.target, 32'h123);
    chk("ow_flush", bb.flush_o, 1'b1);
    cyc();

    // 4-word memory: 20 bytes offered
    sb.load_start = 1; cyc(); sb.load_start = 0;
    for (int i = 0; i < 20; i++) begin
      sb.byte_valid = 1; sb.byte_data = 8'(i);
      if (!sb.byte_ready) cyc();
      cyc();
    end
    sb.byte_valid = 0;
    chk("ov_nwr", s_wr_n, 4);
    chk("ov_first", s_first, 32'h0302_0100);
    chk("ov_lastaddr", s_last_addr, 32'd3);
    chk("ov_ready", sb.byte_ready, 1'b0);
    chk("ov_flag", sb.overflow, 1'b1);
    sb.load_end = 1; cyc(); sb.load_end = 0;
    for (int k = 0; k < 20 && sb.busy; k++) cyc();
    chk("ov_idle", sb.busy, 1'b0);
    chk("ov_loaded", sb.loaded_words, 4);

    // reset in the middle of a word
    wr_n = 0;
    big_start();
    big_byte(8'h01);
    big_byte(8'h02);
    nrst = 1'b0;
    cyc(); cyc();
    chk("mr_loaded", bb.loaded_words, 0);
    chk("mr_pcsel_rst", bb.pcsel, 2'b01);
    nrst = 1'b1;
    chk("mr_flush", bb.flush_o, 1'b1);
    cyc(); cyc();
    chk("mr_pcsel_run", bb.pcsel, 2'b00);
    chk("mr_busy", bb.busy, 1'b0);
    chk("mr_nwr", wr_n, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
